// File: rtl/score_peak_tracker.sv
// Per-frame arg-max of the template-match score stream inside a window around
// the box centre, with a consecutive-miss counter that raises lost.
module score_peak_tracker #(
  parameter int                 SCORE_W     = 16,
  parameter int                 SEARCH_R    = 64,
  parameter logic [SCORE_W-1:0] THRESH      = 16'd1024,
  parameter int                 LOST_FRAMES = 4,
  parameter logic [9:0]         DEF_X       = 10'd320,
  parameter logic [9:0]         DEF_Y       = 10'd240
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic               frame_end,
  input  logic               score_valid,
  input  logic [SCORE_W-1:0] score,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic [9:0]         center_x,
  input  logic [9:0]         center_y,
  input  logic               full_search,
  output logic [9:0]         max_x,
  output logic [9:0]         max_y,
  output logic [SCORE_W-1:0] max_score,
  output logic               max_ready,
  output logic               lost,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

  localparam logic [10:0] RADIUS = 11'(SEARCH_R);
  localparam logic [3:0]  LOST_N = 4'(LOST_FRAMES);

  state_t             state_q, state_d;
  logic [9:0]         wcx_q, wcx_d, wcy_q, wcy_d;
  logic               found_q, found_d;
  logic [SCORE_W-1:0] best_q, best_d;
  logic [9:0]         bx_q, bx_d, by_q, by_d;
  logic [3:0]         miss_q, miss_d;
  logic [9:0]         max_x_q, max_x_d, max_y_q, max_y_d;
  logic [SCORE_W-1:0] max_score_q, max_score_d;
  logic               ready_q, ready_d, lost_q, lost_d;

  logic [10:0]        cx_eff, cy_eff, x_ext, y_ext;
  logic               in_window, scanning, take, do_report;
  logic               acc_found;
  logic [SCORE_W-1:0] acc_best;
  logic [3:0]         miss_inc;

  // A frame_start sample is judged against the freshly latched centre and a cleared accumulator.
  always_comb begin
    cx_eff    = {1'b0, frame_start ? center_x : wcx_q};
    cy_eff    = {1'b0, frame_start ? center_y : wcy_q};
    x_ext     = {1'b0, x};
    y_ext     = {1'b0, y};
    in_window = full_search ||
                ((x_ext + RADIUS >= cx_eff) && (x_ext <= cx_eff + RADIUS) &&
                 (y_ext + RADIUS >= cy_eff) && (y_ext <= cy_eff + RADIUS));
    acc_found = frame_start ? 1'b0 : found_q;
    acc_best  = frame_start ? '0 : best_q;
    scanning  = frame_start || (state_q == SCAN);
    take      = scanning && score_valid && in_window && (score >= THRESH) &&
                (!acc_found || (score > acc_best));
    do_report = (state_q == SCAN) && frame_end && !frame_start;
    miss_inc  = (miss_q == 4'hF) ? miss_q : miss_q + 4'd1;
  end

  always_comb begin
    state_d     = state_q;
    wcx_d       = wcx_q;
    wcy_d       = wcy_q;
    found_d     = acc_found;
    best_d      = acc_best;
    bx_d        = bx_q;
    by_d        = by_q;
    miss_d      = miss_q;
    max_x_d     = max_x_q;
    max_y_d     = max_y_q;
    max_score_d = max_score_q;
    ready_d     = 1'b0;
    lost_d      = lost_q;

    if (frame_start) begin
      state_d = SCAN;
      wcx_d   = center_x;
      wcy_d   = center_y;
    end else begin
      case (state_q)
        SCAN:    if (frame_end) state_d = REPORT;
        REPORT:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    if (take) begin
      found_d = 1'b1;
      best_d  = score;
      bx_d    = x;
      by_d    = y;
    end

    if (do_report) begin
      if (found_d) begin
        max_x_d     = bx_d;
        max_y_d     = by_d;
        max_score_d = best_d;
        ready_d     = 1'b1;
        miss_d      = 4'd0;
        lost_d      = 1'b0;
      end else begin
        miss_d = miss_inc;
        if (miss_inc >= LOST_N) lost_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wcx_q       <= DEF_X;
      wcy_q       <= DEF_Y;
      found_q     <= 1'b0;
      best_q      <= '0;
      bx_q        <= DEF_X;
      by_q        <= DEF_Y;
      miss_q      <= 4'd0;
      max_x_q     <= DEF_X;
      max_y_q     <= DEF_Y;
      max_score_q <= '0;
      ready_q     <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcx_q       <= wcx_d;
      wcy_q       <= wcy_d;
      found_q     <= found_d;
      best_q      <= best_d;
      bx_q        <= bx_d;
      by_q        <= by_d;
      miss_q      <= miss_d;
      max_x_q     <= max_x_d;
      max_y_q     <= max_y_d;
      max_score_q <= max_score_d;
      ready_q     <= ready_d;
      lost_q      <= lost_d;
    end
  end

  assign max_x     = max_x_q;
  assign max_y     = max_y_q;
  assign max_score = max_score_q;
  assign max_ready = ready_q;
  assign lost      = lost_q;
  assign busy      = (state_q == SCAN);

endmodule
